// File: rtl/with_mux.sv
// 2x2 unsigned multiplier built from four 4:1 muxes selected by {a,b}, with a registered output stage.
// Latency: one clk cycle from in_valid to out_valid. The result is held while in_valid is low.
// Backpressure: none. It accepts one operand pair per cycle and never stalls. Optional parity output: WITH_MUX_PARITY_EN.
module with_mux #(
    parameter logic [3:0] OUT_RST = 4'b0000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic out_valid,
`ifdef WITH_MUX_PARITY_EN
    output logic f_par,
`endif
    output logic f0,
    output logic f1,
    output logic f2,
    output logic f3
);

    logic [3:0] prod;       // combinational mux-core product {f3,f2,f1,f0}
    logic [3:0] f_d;
    logic [3:0] f_q;
    logic       out_valid_d;
    logic       out_valid_q;
`ifdef WITH_MUX_PARITY_EN
    logic       f_par_d;
    logic       f_par_q;
`endif

    // Mux core: each product bit is a 4:1 mux on {a,b}. Its data inputs are functions of c and d.
    always_comb begin
        prod = 4'b0000;
        case ({a, b})
            2'b00: prod = 4'b0000;
            2'b01: prod = {1'b0, 1'b0, c, d};
            2'b10: prod = {1'b0, c, d, 1'b0};
            2'b11: prod = {c & d, c & ~d, c ^ d, d};
            default: prod = 4'b0000;
        endcase
    end

    // Next-state logic: capture the product on a valid input, otherwise hold it. Valid follows in_valid.
    always_comb begin
        out_valid_d = in_valid;
        f_d         = in_valid ? prod : f_q;
`ifdef WITH_MUX_PARITY_EN
        f_par_d     = in_valid ? ^prod : f_par_q;
`endif
    end

    // Output register with asynchronous reset. Reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q         <= OUT_RST;
            out_valid_q <= 1'b0;
`ifdef WITH_MUX_PARITY_EN
            f_par_q     <= 1'b0;
`endif
        end else begin
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
`ifdef WITH_MUX_PARITY_EN
            f_par_q     <= f_par_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign f0        = f_q[0];
    assign f1        = f_q[1];
    assign f2        = f_q[2];
    assign f3        = f_q[3];
`ifdef WITH_MUX_PARITY_EN
    assign f_par     = f_par_q;
`endif

endmodule

// File: tb/tb_with_mux.sv
// Directed testbench for with_mux: reset, exhaustive sweep, hold, mid-stream reset, optional parity.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after the rising edge.
// Expected values are hand-computed constants from the product truth table.
module tb_with_mux;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic a, b, c, d;
    logic out_valid;
    logic f0, f1, f2, f3;
`ifdef WITH_MUX_PARITY_EN
    logic f_par;
`endif

    int n_cmp;
    int n_err;

    // Expected product for index {a,b,c,d} = 0..15
    logic [3:0] exp_tab [16] = '{4'd0, 4'd0, 4'd0, 4'd0,
                                 4'd0, 4'd1, 4'd2, 4'd3,
                                 4'd0, 4'd2, 4'd4, 4'd6,
                                 4'd0, 4'd3, 4'd6, 4'd9};

    with_mux #(.OUT_RST(4'b0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
`ifdef WITH_MUX_PARITY_EN
        .f_par     (f_par),
`endif
        .f0        (f0),
        .f1        (f1),
        .f2        (f2),
        .f3        (f3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one operand set on the falling edge, then move to just after the next rising edge.
    task automatic step(input logic v, input logic [3:0] abcd);
        @(negedge clk);
        in_valid = v;
        {a, b, c, d} = abcd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] fout();
        return {f3, f2, f1, f0};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        in_valid = 1'b0;
        {a, b, c, d} = 4'b0000;

        // The reset edge falls between clock edges. The outputs must clear with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_f", fout(), 4'b0000);
        chk("rst_vld", {3'b0, out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i));
            chk($sformatf("sweep_f_%0d", i), fout(), exp_tab[i]);
            chk($sformatf("sweep_vld_%0d", i), {3'b0, out_valid}, 4'b0001);
        end

        // Hold: capture 9. Operand changes with in_valid low must not change the output.
        step(1'b1, 4'b1111);
        chk("hold_cap", fout(), 4'b1001);
        step(1'b0, 4'b0101);
        chk("hold_f", fout(), 4'b1001);
        chk("hold_vld", {3'b0, out_valid}, 4'b0000);
        step(1'b0, 4'b1010);
        chk("hold_f2", fout(), 4'b1001);

        // Mid-stream reset at 1110
        step(1'b1, 4'b1101);
        chk("ms_pre1", fout(), 4'b0011);
        step(1'b1, 4'b1110);
        chk("ms_pre2", fout(), 4'b0110);
        #2 rst_n = 1'b0;
        #1;
        chk("ms_rst_f", fout(), 4'b0000);
        chk("ms_rst_vld", {3'b0, out_valid}, 4'b0000);
        step(1'b1, 4'b1111);
        chk("ms_inrst_f", fout(), 4'b0000);
        chk("ms_inrst_vld", {3'b0, out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b1011);
        chk("ms_post_f", fout(), 4'b0110);
        chk("ms_post_vld", {3'b0, out_valid}, 4'b0001);

`ifdef WITH_MUX_PARITY_EN
        step(1'b1, 4'b1111);
        chk("par_f_1111", fout(), 4'b1001);
        chk("par_1111", {3'b0, f_par}, 4'b0000);
        step(1'b1, 4'b1101);
        chk("par_f_1101", fout(), 4'b0011);
        chk("par_1101", {3'b0, f_par}, 4'b0000);
        step(1'b1, 4'b0110);
        chk("par_f_0110", fout(), 4'b0010);
        chk("par_0110", {3'b0, f_par}, 4'b0001);
        step(1'b0, 4'b1111);
        chk("par_hold", {3'b0, f_par}, 4'b0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
